// File: rtl/exec_unit_scheduler.sv
// exec_unit_scheduler: classifies the EX-stage alu_t and sequences ALU, MUL, DIV and FPU
// units with stall, start/abort handshakes and a single writeback pulse.
package exec_unit_scheduler_pkg;
    typedef enum logic [5:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
        ALU_FADD, ALU_FSUB, ALU_FMUL, ALU_FDIV, ALU_FSQRT,
        ALU_FMADD, ALU_FMSUB, ALU_FNMSUB, ALU_FNMADD,
        ALU_FSGNJ, ALU_FSGNJN, ALU_FSGNJX, ALU_FMIN, ALU_FMAX,
        ALU_FLE, ALU_FLT, ALU_FEQ, ALU_FMVXW, ALU_FMVWX, ALU_FCLASS,
        ALU_FCVTWS, ALU_FCVTWUS, ALU_FCVTSW, ALU_FCVTSWU
    } alu_t;
endpackage

module exec_unit_scheduler
    import exec_unit_scheduler_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int FPU_LAT = 4,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  alu_t       alu_ctrl,
    input  logic       flush,
    input  logic       div_done,
    input  logic       fpu_done,
    output logic       stall,
    output logic       div_start,
    output logic       fpu_start,
    output logic       unit_abort,
    output logic       wb_valid,
    output logic [1:0] wb_sel,
    output logic       busy,
    output logic       timeout_err
);
    localparam int CW = $clog2(TIMEOUT + MUL_LAT + FPU_LAT);

    typedef enum logic [2:0] {IDLE, MUL_WAIT, FIX_WAIT, DIV_WAIT, FLONG_WAIT, DONE} state_t;
    typedef enum logic [2:0] {C_SINGLE, C_MUL, C_DIV, C_FFIX, C_FLONG} cls_t;

    state_t        state, nstate;
    cls_t          cls;
    logic [CW-1:0] cnt, ncnt;
    logic [1:0]    sel_q, nsel;
    logic          start, done;

    always_comb begin
        case (alu_ctrl)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: cls = C_MUL;
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: cls = C_DIV;
            ALU_FADD, ALU_FSUB, ALU_FMUL, ALU_FMADD,
            ALU_FMSUB, ALU_FNMSUB, ALU_FNMADD: cls = C_FFIX;
            ALU_FDIV, ALU_FSQRT: cls = C_FLONG;
            default: cls = C_SINGLE;
        endcase
    end

    assign done = (state == DIV_WAIT) ? div_done : fpu_done;

    always_comb begin
        nstate      = state;
        ncnt        = cnt;
        nsel        = sel_q;
        stall       = 1'b0;
        start       = 1'b0;
        unit_abort  = 1'b0;
        wb_valid    = 1'b0;
        wb_sel      = 2'd0;
        timeout_err = 1'b0;
        case (state)
            IDLE: if (issue_valid && !flush) begin
                case (cls)
                    C_MUL: begin
                        stall  = 1'b1;
                        ncnt   = CW'(MUL_LAT - 2);
                        nsel   = 2'd1;
                        nstate = MUL_WAIT;
                    end
                    C_FFIX: begin
                        stall  = 1'b1;
                        ncnt   = CW'(FPU_LAT - 2);
                        nsel   = 2'd3;
                        nstate = FIX_WAIT;
                    end
                    C_DIV: begin
                        stall  = 1'b1;
                        ncnt   = '0;
                        nsel   = 2'd2;
                        nstate = DIV_WAIT;
                    end
                    C_FLONG: begin
                        stall  = 1'b1;
                        ncnt   = '0;
                        nsel   = 2'd3;
                        nstate = FLONG_WAIT;
                    end
                    default: wb_valid = 1'b1;
                endcase
            end
            MUL_WAIT, FIX_WAIT: begin
                if (flush) nstate = IDLE;
                else begin
                    stall = 1'b1;
                    if (cnt == '0) nstate = DONE;
                    else ncnt = cnt - 1'b1;
                end
            end
            DIV_WAIT, FLONG_WAIT: begin
                if (flush) begin
                    unit_abort = 1'b1;
                    nstate     = IDLE;
                end else begin
                    stall = 1'b1;
                    start = (cnt == '0);
                    // done in the start-pulse cycle belongs to no launch of ours
                    if (done && cnt != '0) nstate = DONE;
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        timeout_err = 1'b1;
                        unit_abort  = 1'b1;
                        nstate      = IDLE;
                    end else ncnt = cnt + 1'b1;
                end
            end
            DONE: begin
                nstate   = IDLE;
                wb_valid = !flush;
                wb_sel   = flush ? 2'd0 : sel_q;
            end
            default: nstate = IDLE;
        endcase
    end

    assign div_start = start && state == DIV_WAIT;
    assign fpu_start = start && state == FLONG_WAIT;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sel_q <= 2'd0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            sel_q <= nsel;
        end
    end
endmodule

// File: tb/tb_exec_unit_scheduler.sv
// tb_exec_unit_scheduler: directed vector table plus hand-written multi-cycle sequences.
module tb_exec_unit_scheduler;
    import exec_unit_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       reset, issue_valid, flush, div_done, fpu_done;
    alu_t       alu_ctrl;
    logic       stall, div_start, fpu_start, unit_abort, wb_valid, busy, timeout_err;
    logic [1:0] wb_sel;
    int         tests = 0;
    int         fails = 0;
    logic       seen;

    exec_unit_scheduler #(.MUL_LAT(3), .FPU_LAT(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .alu_ctrl(alu_ctrl),
        .flush(flush), .div_done(div_done), .fpu_done(fpu_done), .stall(stall),
        .div_start(div_start), .fpu_start(fpu_start), .unit_abort(unit_abort),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_t       op;
        logic       v;
        logic       fl;
        logic       wv;
        logic [1:0] ws;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input alu_t op, input logic fl,
                       input logic dd, input logic fd, input logic rst);
        @(posedge clk);
        #1;
        issue_valid = v;
        alu_ctrl    = op;
        flush       = fl;
        div_done    = dd;
        fpu_done    = fd;
        reset       = rst;
        #1;
    endtask

    task automatic all_zero(input string name);
        check({name, " outs"},
              {stall, div_start, fpu_start, unit_abort, wb_valid, wb_sel, busy, timeout_err}, 0);
    endtask

    initial begin
        tbl[0] = '{ALU_ADD,       1, 0, 1, 0};
        tbl[1] = '{ALU_FSGNJX,    1, 0, 1, 0};
        tbl[2] = '{ALU_FCVTSW,    1, 0, 1, 0};
        tbl[3] = '{ALU_FEQ,       1, 0, 1, 0};
        tbl[4] = '{ALU_LUI,       1, 0, 1, 0};
        tbl[5] = '{alu_t'(6'd55), 1, 0, 1, 0};
        tbl[6] = '{ALU_ADD,       1, 1, 0, 0};
        tbl[7] = '{ALU_MUL,       0, 0, 0, 0};
        tbl[8] = '{ALU_FDIV,      1, 1, 0, 0};

        cyc(0, ALU_ADD, 0, 0, 0, 1);
        cyc(0, ALU_ADD, 0, 0, 0, 1);
        all_zero("reset");
        cyc(0, ALU_ADD, 0, 0, 0, 0);
        all_zero("post-reset idle");

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].v, tbl[i].op, tbl[i].fl, 0, 0, 0);
            check($sformatf("vec%0d wb_valid", i), wb_valid, tbl[i].wv);
            check($sformatf("vec%0d wb_sel", i), wb_sel, tbl[i].ws);
            check($sformatf("vec%0d stall", i), stall, 0);
            check($sformatf("vec%0d busy", i), busy, 0);
        end
        cyc(0, ALU_ADD, 0, 0, 0, 0);
        check("table leaves idle", busy, 0);

        // MUL issued at T
        cyc(1, ALU_MULHU, 0, 0, 0, 0);
        check("mul T stall", {stall, wb_valid}, 2'b10);
        cyc(1, ALU_MULHU, 0, 0, 0, 0);
        check("mul T+1 stall/busy", {stall, busy, wb_valid}, 3'b110);
        cyc(1, ALU_MULHU, 0, 0, 0, 0);
        check("mul T+2 stall", {stall, wb_valid}, 2'b10);
        cyc(1, ALU_MULHU, 0, 0, 0, 0);
        check("mul T+3 wb", {stall, wb_valid, wb_sel}, 4'b0101);
        cyc(0, ALU_ADD, 0, 0, 0, 0);
        check("mul T+4 idle", {busy, wb_valid}, 0);

        // FADD: stall T..T+3, wb at T+4
        cyc(1, ALU_FADD, 0, 0, 0, 0);
        seen = stall;
        for (int k = 1; k < 4; k++) begin
            cyc(1, ALU_FADD, 0, 0, 0, 0);
            seen = seen & stall & !wb_valid;
        end
        check("fadd stall window", seen, 1);
        cyc(1, ALU_FADD, 0, 0, 0, 0);
        check("fadd T+4 wb", {stall, wb_valid, wb_sel}, 4'b0111);
        cyc(0, ALU_ADD, 0, 0, 0, 0);

        // DIV at T, spurious done at T+1, real done at T+10
        cyc(1, ALU_REM, 0, 0, 0, 0);
        check("div T", {stall, div_start}, 2'b10);
        cyc(1, ALU_REM, 0, 1, 0, 0);
        check("div T+1 start", {stall, div_start, fpu_start}, 3'b110);
        seen = 1'b1;
        for (int k = 2; k < 10; k++) begin
            cyc(1, ALU_REM, 0, 0, k == 4, 0);
            seen = seen & stall & !div_start & !wb_valid;
        end
        check("div wait window", seen, 1);
        cyc(1, ALU_REM, 0, 1, 0, 0);
        check("div T+10 stall", {stall, wb_valid}, 2'b10);
        cyc(1, ALU_REM, 0, 0, 0, 0);
        check("div T+11 wb", {stall, wb_valid, wb_sel}, 4'b0110);
        cyc(0, ALU_ADD, 0, 0, 0, 0);
        check("div T+12 idle", busy, 0);

        // FSQRT flushed at T+5
        cyc(1, ALU_FSQRT, 0, 0, 0, 0);
        cyc(1, ALU_FSQRT, 0, 0, 0, 0);
        check("fsqrt start", fpu_start, 1);
        cyc(1, ALU_FSQRT, 0, 1, 0, 0);
        for (int k = 3; k < 5; k++) cyc(1, ALU_FSQRT, 0, 0, 0, 0);
        check("fsqrt ignores div_done", {busy, stall}, 2'b11);
        cyc(1, ALU_FSQRT, 1, 0, 0, 0);
        check("fsqrt flush", {stall, unit_abort, wb_valid, fpu_start}, 4'b0100);
        cyc(0, ALU_ADD, 0, 0, 1, 0);
        check("fsqrt after flush", {busy, wb_valid, stall, unit_abort}, 0);

        // FDIV never completes
        cyc(1, ALU_FDIV, 0, 0, 0, 0);
        seen = 1'b0;
        for (int k = 1; k < 64; k++) begin
            cyc(1, ALU_FDIV, 0, 0, 0, 0);
            seen = seen | timeout_err | unit_abort | wb_valid | !stall;
        end
        check("fdiv no early timeout", seen, 0);
        cyc(1, ALU_FDIV, 0, 0, 0, 0);
        check("fdiv timeout", {timeout_err, unit_abort, wb_valid}, 3'b110);
        cyc(0, ALU_ADD, 0, 0, 0, 0);
        check("fdiv after timeout", {busy, wb_valid, timeout_err}, 0);

        // flush in MUL_WAIT: no abort
        cyc(1, ALU_MUL, 0, 0, 0, 0);
        cyc(1, ALU_MUL, 1, 0, 0, 0);
        check("mul flush", {stall, unit_abort, wb_valid}, 0);
        cyc(0, ALU_ADD, 0, 0, 0, 0);
        check("mul flush idle", busy, 0);

        // flush beats done, and flush in DONE kills wb
        cyc(1, ALU_DIV, 0, 0, 0, 0);
        cyc(1, ALU_DIV, 0, 0, 0, 0);
        cyc(1, ALU_DIV, 1, 1, 0, 0);
        check("flush over done", {unit_abort, stall, wb_valid}, 3'b100);
        cyc(0, ALU_ADD, 0, 0, 0, 0);
        check("flush over done idle", busy, 0);
        cyc(1, ALU_MUL, 0, 0, 0, 0);
        cyc(1, ALU_MUL, 0, 0, 0, 0);
        cyc(1, ALU_MUL, 0, 0, 0, 0);
        cyc(1, ALU_MUL, 1, 0, 0, 0);
        check("flush in done", {wb_valid, wb_sel, busy}, 4'b0001);
        cyc(0, ALU_ADD, 0, 0, 0, 0);
        check("flush in done idle", busy, 0);

        // FMADD reset mid-flight
        cyc(1, ALU_FMADD, 0, 0, 0, 0);
        cyc(1, ALU_FMADD, 0, 0, 0, 0);
        cyc(0, ALU_FMADD, 0, 0, 0, 1);
        cyc(0, ALU_ADD, 0, 0, 0, 0);
        all_zero("reset mid-op");
        cyc(1, ALU_ADD, 0, 0, 0, 0);
        check("add after reset", {wb_valid, wb_sel, stall, busy}, 5'b10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
